// File: rtl/core_alu_sched_pkg.sv
// Shared types for the ALU issue scheduler: decode word, write-back line,
// request bundle and scheduler state encoding.
package core_alu_sched_pkg;

  localparam int NREG = 16;
  localparam int RW   = 4;

  typedef logic [NREG-1:0] hword;
  typedef logic [15:0]     word;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [7:0]    imm;
  } dec_data_t;

  typedef struct packed {
    logic [3:0] opc;
    dec_data_t  data;
  } insn_decode;

  typedef struct packed {
    logic          ready;
    logic [RW-1:0] rd;
    word           value;
  } wb_line;

  typedef struct packed {
    insn_decode dec;
    hword       src;
    word        a;
    word        b;
  } alu_req;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_ISSUE,
    SCHED_DRAIN
  } sched_state;

  localparam int DEC_W = $bits(insn_decode);
  localparam int WB_W  = $bits(wb_line);

  function automatic hword reg_bit(input logic [RW-1:0] r);
    return hword'(1) << r;
  endfunction

endpackage

// File: rtl/core_rr_arbiter.sv
// One-hot arbiter: aged requesters win lowest-index first, otherwise
// round-robin starting at rr_ptr_i.
module core_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  elig_i,
  input  logic [N-1:0]  aged_i,
  input  logic [PW-1:0] rr_ptr_i,
  output logic [N-1:0]  grant_o
);

  logic found;

  // Two passes replace a modular index: first at/after the pointer, then wrap.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    if (|aged_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && aged_i[i]) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end else begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && elig_i[j] && (j >= 32'(rr_ptr_i))) begin
          grant_o[j] = 1'b1;
          found      = 1'b1;
        end
      end
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && elig_i[j]) begin
          grant_o[j] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/core_alu_sched.sv
// Issue scheduler sharing one single-cycle ALU between N decode lanes, with a
// register scoreboard, aging round-robin arbitration and a registered operand stage.
module core_alu_sched
  import core_alu_sched_pkg::*;
#(
  parameter int N        = 2,
  parameter int W        = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req_valid,
  input  logic [N-1:0][DEC_W-1:0] req_dec,
  input  logic [N-1:0][NREG-1:0]  req_src,
  input  logic [N-1:0][W-1:0]     req_a,
  input  logic [N-1:0][W-1:0]     req_b,
  output logic [N-1:0]            req_ready,
  output logic                    alu_start,
  output logic [DEC_W-1:0]        alu_dec,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  input  logic [WB_W-1:0]         wb,
  input  logic                    flush,
  output logic [NREG-1:0]         busy_regs,
  output logic                    idle
);

  localparam int            PW       = (N > 2) ? 2 : 1;
  localparam int            CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

  sched_state           state_q, state_d;
  hword                 busy_q, busy_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [N-1:0][CW-1:0] wait_q, wait_d;
  logic                 start_q;
  insn_decode           dec_q;
  logic [W-1:0]         a_q, b_q;

  insn_decode   dec_l [N];
  wb_line       wb_s;
  logic [N-1:0] elig, aged, grant;
  logic         issue_ok, any_g;
  logic [PW-1:0] gidx;
  insn_decode   g_dec;
  logic [W-1:0] g_a, g_b;
  logic         wb_value_unused;

  assign wb_s            = wb_line'(wb);
  assign wb_value_unused = ^wb_s.value;

  // rst_n gates issue so req_ready drops the moment reset asserts.
  assign issue_ok = rst_n & ~flush & (state_q != SCHED_DRAIN);

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      dec_l[i] = insn_decode'(req_dec[i]);
      elig[i]  = issue_ok & req_valid[i] & ~|(req_src[i] & busy_q)
                 & ~busy_q[dec_l[i].data.rd];
      aged[i]  = elig[i] & (wait_q[i] >= WAIT_SAT);
    end
  end

  core_rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_arb (
    .elig_i   (elig),
    .aged_i   (aged),
    .rr_ptr_i (rr_q),
    .grant_o  (grant)
  );

  always_comb begin
    any_g = |grant;
    gidx  = '0;
    g_dec = '0;
    g_a   = '0;
    g_b   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        gidx  = PW'(i);
        g_dec = dec_l[i];
        g_a   = req_a[i];
        g_b   = req_b[i];
      end
    end
  end

  // Clear applied before set so a same-edge retire and re-issue leaves the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_s.ready) busy_d = busy_d & ~reg_bit(wb_s.rd);
    if (any_g)      busy_d = busy_d | reg_bit(g_dec.data.rd);

    rr_d = rr_q;
    if (any_g) rr_d = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;

    for (int unsigned i = 0; i < N; i++) begin
      if (!req_valid[i] || grant[i])  wait_d[i] = '0;
      else if (wait_q[i] < WAIT_SAT)  wait_d[i] = wait_q[i] + 1'b1;
      else                            wait_d[i] = wait_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = SCHED_DRAIN;
    end else begin
      case (state_q)
        SCHED_IDLE:  if (any_g)                  state_d = SCHED_ISSUE;
        SCHED_ISSUE: if (!any_g && busy_q == '0) state_d = SCHED_IDLE;
        SCHED_DRAIN: if (busy_q == '0)           state_d = SCHED_IDLE;
        default:                                 state_d = SCHED_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCHED_IDLE;
      busy_q  <= '0;
      rr_q    <= '0;
      wait_q  <= '0;
      start_q <= 1'b0;
      dec_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      wait_q  <= wait_d;
      start_q <= any_g;
      if (any_g) begin
        dec_q <= g_dec;
        a_q   <= g_a;
        b_q   <= g_b;
      end
    end
  end

  assign req_ready = grant;
  assign alu_start = start_q;
  assign alu_dec   = dec_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign busy_regs = busy_q;
  assign idle      = (state_q == SCHED_IDLE) && (busy_q == '0);

endmodule

// File: tb/tb_core_alu_sched.sv
// Self-checking bench for core_alu_sched (N=3, MAX_WAIT=2): directed scenarios
// plus random traffic against a cycle-level reference model; the bench acts as the ALU.
module tb_core_alu_sched;
  import core_alu_sched_pkg::*;

  localparam int NL   = 3;
  localparam int MAXW = 2;

  logic                     clk, rst_n;
  logic [NL-1:0]            req_valid;
  logic [NL-1:0][DEC_W-1:0] req_dec;
  logic [NL-1:0][15:0]      req_src;
  logic [NL-1:0][15:0]      req_a, req_b;
  logic [NL-1:0]            req_ready;
  logic                     alu_start;
  logic [DEC_W-1:0]         alu_dec;
  logic [15:0]              alu_a, alu_b;
  logic [WB_W-1:0]          wb;
  logic                     flush;
  logic [15:0]              busy_regs;
  logic                     idle;

  core_alu_sched #(.N(NL), .W(16), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_dec(req_dec),
    .req_src(req_src), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .alu_start(alu_start), .alu_dec(alu_dec), .alu_a(alu_a), .alu_b(alu_b),
    .wb(wb), .flush(flush), .busy_regs(busy_regs), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // stimulus state
  alu_req        lane [NL];
  logic [NL-1:0] vld;
  logic          inj;
  logic [3:0]    inj_rd;
  wb_line        wbv;

  // reference model
  logic [15:0] m_busy;
  int          m_wait [NL];
  int          m_ptr, m_st;   // m_st: 0 idle, 1 issuing, 2 draining
  logic        m_start;
  insn_decode  m_dec;
  logic [15:0] m_a, m_b;
  logic        wb_pend;
  logic [3:0]  wb_rd;
  int          last_g;
  logic [NL-1:0] o_ready;
  logic        o_idle;
  int          rot [NL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NL; i++) begin
      req_valid[i] = vld[i];
      req_dec[i]   = lane[i].dec;
      req_src[i]   = lane[i].src;
      req_a[i]     = lane[i].a;
      req_b[i]     = lane[i].b;
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] rd, input logic [15:0] src,
                        input logic [15:0] a, input logic [15:0] b);
    lane[i].dec.opc      = 4'($urandom);
    lane[i].dec.data.rd  = rd;
    lane[i].dec.data.imm = 8'($urandom);
    lane[i].src          = src;
    lane[i].a            = a;
    lane[i].b            = b;
    vld[i]               = 1'b1;
  endtask

  task automatic m_reset();
    m_busy = '0; m_ptr = 0; m_st = 0; m_start = 1'b0; m_dec = '0;
    m_a = '0; m_b = '0; wb_pend = 1'b0; wb_rd = '0; inj = 1'b0;
    for (int i = 0; i < NL; i++) m_wait[i] = 0;
  endtask

  function automatic bit m_elig(input int i);
    return rst_n && !flush && m_st != 2 && vld[i] &&
           ((lane[i].src & m_busy) == 16'h0) && !m_busy[lane[i].dec.data.rd];
  endfunction

  // Starving lanes first (lowest index), else first eligible scanning from the pointer.
  function automatic int model_grant();
    for (int i = 0; i < NL; i++)
      if (m_elig(i) && m_wait[i] >= MAXW) return i;
    for (int k = 0; k < NL; k++)
      if (m_elig((m_ptr + k) % NL)) return (m_ptr + k) % NL;
    return -1;
  endfunction

  task automatic step();
    int          g;
    logic [2:0]  er;
    logic [15:0] nb;
    wbv = '0;
    if (wb_pend) begin
      wbv.ready = 1'b1; wbv.rd = wb_rd; wbv.value = 16'($urandom);
    end else if (inj) begin
      wbv.ready = 1'b1; wbv.rd = inj_rd;
    end
    wb = wbv;
    apply();
    #1;
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    o_ready = req_ready;
    o_idle  = idle;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("alu_start", 32'(alu_start), 32'(m_start));
    if (m_start) begin
      chk("alu_a",   32'(alu_a),   32'(m_a));
      chk("alu_b",   32'(alu_b),   32'(m_b));
      chk("alu_dec", 32'(alu_dec), 32'(m_dec));
    end
    chk("busy_regs", 32'(busy_regs), 32'(m_busy));
    chk("idle", 32'(idle), 32'(m_st == 0 && m_busy == 16'h0));
    last_g = g;
    @(posedge clk);
    nb = m_busy;
    if (wbv.ready) nb[wbv.rd] = 1'b0;
    if (g >= 0)    nb[lane[g].dec.data.rd] = 1'b1;
    if (flush)                                  m_st = 2;
    else if (m_st == 0 && g >= 0)               m_st = 1;
    else if (m_st == 1 && g < 0 && m_busy == 0) m_st = 0;
    else if (m_st == 2 && m_busy == 0)          m_st = 0;
    for (int i = 0; i < NL; i++) begin
      if (!vld[i] || i == g)    m_wait[i] = 0;
      else if (m_wait[i] < MAXW) m_wait[i]++;
    end
    if (g >= 0) m_ptr = (g + 1) % NL;
    wb_pend = m_start;
    wb_rd   = m_dec.data.rd;
    m_start = (g >= 0);
    if (g >= 0) begin
      m_dec = lane[g].dec; m_a = lane[g].a; m_b = lane[g].b;
    end
    m_busy = nb;
    inj    = 1'b0;
    #1;
  endtask

  task automatic drain(input int n);
    vld = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Lane 0 cycles r10..r12, lane 1 cycles r13..r15 so neither self-blocks.
  task automatic stream_next();
    if (last_g == 0 || last_g == 1) begin
      rot[last_g]++;
      set_op(last_g, 4'(10 + 3 * last_g + rot[last_g] % 3), '0, 16'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    bit saw_idle, saw_grant;
    rst_n = 1'b0; flush = 1'b0; vld = '0; wb = '0;
    for (int i = 0; i < NL; i++) begin lane[i] = '0; rot[i] = 0; end
    apply();
    m_reset();
    #12;
    chk("rst_start", 32'(alu_start), 32'(0));
    chk("rst_busy",  32'(busy_regs), 32'(0));
    chk("rst_alu_a", 32'(alu_a),     32'(0));
    chk("rst_dec",   32'(alu_dec),   32'(0));
    chk("rst_idle",  32'(idle),      32'(1));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single op
    set_op(0, 4'd3, 16'h0006, 16'd5, 16'd7);
    step();
    chk("t1_ready", 32'(o_ready), 32'(3'b001));
    vld = '0;
    chk("t1_start", 32'(alu_start), 32'(1));
    chk("t1_a",     32'(alu_a),     32'(5));
    chk("t1_b",     32'(alu_b),     32'(7));
    chk("t1_busy",  32'(busy_regs), 32'(16'h0008));
    step();
    step();
    chk("t1_busy_clr", 32'(busy_regs), 32'(0));

    // RAW on r3
    set_op(0, 4'd3, '0, 16'd1, 16'd2);
    step(); vld[0] = 1'b0;
    set_op(1, 4'd3, 16'h0008, 16'd3, 16'd4);
    step(); chk("t2_hold1", 32'(o_ready), 32'(0));
    step(); chk("t2_hold2", 32'(o_ready), 32'(0));
    step(); chk("t2_grant", 32'(o_ready), 32'(3'b010));
    vld = '0;
    chk("t2_busy3", 32'(busy_regs[3]), 32'(1));
    drain(3);

    // fairness
    set_op(0, 4'd10, '0, 16'($urandom), 16'($urandom));
    set_op(1, 4'd13, '0, 16'($urandom), 16'($urandom));
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t3_alt",   32'(o_ready),   32'((k % 2 == 0) ? 3'b001 : 3'b010));
      chk("t3_start", 32'(alu_start), 32'(1));
      stream_next();
    end
    drain(4);

    // aging: lane 2 blocked on r5 while lanes 0/1 alternate
    set_op(0, 4'd5, '0, 16'd11, 16'd12);
    step();
    set_op(0, 4'd6, '0, 16'd13, 16'd14);
    set_op(1, 4'd7, '0, 16'd15, 16'd16);
    set_op(2, 4'd1, 16'h0020, 16'd17, 16'd18);
    step(); chk("t4_c1", 32'(o_ready), 32'(3'b010));
    set_op(1, 4'd8, '0, 16'd19, 16'd20);
    step(); chk("t4_c2", 32'(o_ready), 32'(3'b001));
    set_op(0, 4'd11, '0, 16'd21, 16'd22);
    step(); chk("t4_aged", 32'(o_ready), 32'(3'b100));
    drain(4);

    // flush in a back-to-back stream
    set_op(0, 4'd10, '0, 16'($urandom), 16'($urandom));
    set_op(1, 4'd13, '0, 16'($urandom), 16'($urandom));
    for (int k = 0; k < 4; k++) begin step(); stream_next(); end
    chk("t5_pending_start", 32'(alu_start), 32'(1));
    flush = 1'b1;
    step(); chk("t5_flush_nogrant", 32'(o_ready), 32'(0));
    flush = 1'b0;
    saw_idle = 1'b0; saw_grant = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (o_idle) saw_idle = 1'b1;
      if (o_ready != 0) saw_grant = 1'b1;
      stream_next();
    end
    chk("t5_idle_seen", 32'(saw_idle),  32'(1));
    chk("t5_resume",    32'(saw_grant), 32'(1));
    drain(4);

    // same-edge set and clear on r4, then a stray wb
    set_op(0, 4'd4, '0, 16'd1, 16'd1);
    inj = 1'b1; inj_rd = 4'd4;
    step(); vld = '0;
    chk("t6_set_wins", 32'(busy_regs), 32'(16'h0010));
    inj = 1'b1; inj_rd = 4'd9;
    step();
    chk("t6_stray_wb", 32'(busy_regs), 32'(16'h0010));
    drain(3);
    chk("t6_drained", 32'(busy_regs), 32'(0));

    // async reset mid-operation
    set_op(0, 4'd3, '0, 16'd2, 16'd3);
    step();
    set_op(0, 4'd4, '0, 16'd4, 16'd5);
    step();
    chk("t7_busy_pre",  32'(busy_regs), 32'(16'h0018));
    chk("t7_start_pre", 32'(alu_start), 32'(1));
    set_op(0, 4'd5, '0, 16'd6, 16'd7);
    apply();
    #2 rst_n = 1'b0;
    #1;
    chk("t7_start", 32'(alu_start), 32'(0));
    chk("t7_busy",  32'(busy_regs), 32'(0));
    chk("t7_ready", 32'(req_ready), 32'(0));
    chk("t7_alu_a", 32'(alu_a),     32'(0));
    m_reset();
    vld = '0; wb = '0; apply();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    inj = 1'b1; inj_rd = 4'd4;
    step();
    chk("t7_stale_wb", 32'(busy_regs), 32'(0));

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NL; i++) begin
        if (!vld[i] && ($urandom % 3 == 0))
          set_op(i, 4'($urandom), ($urandom % 2 == 1) ? reg_bit(4'($urandom)) : 16'h0,
                 16'($urandom), 16'($urandom));
      end
      flush = ($urandom % 40 == 0);
      if (!wb_pend && ($urandom % 10 == 0)) begin inj = 1'b1; inj_rd = 4'($urandom); end
      step();
      if (last_g >= 0) vld[last_g] = 1'b0;
    end
    flush = 1'b0;
    drain(5);
    chk("final_idle", 32'(idle), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
